// File: rtl/avsdpll_lock_det_if.sv
// ---------------------------------------------------------------------------
// avsdpll_lock_det_if
// Signal bundle between the PLL environment and the avsdpll lock detector.
//
// Parameters:
//   CW          width of the measured period count
// Signals:
//   ref_clk     reference clock, asynchronous to the detector clock
//   en_mon      monitor enable (low holds the detector idle)
//   count       CLK cycles measured in the last complete REF period
//   count_valid one-cycle pulse when count updates
//   lock        lock indication
//   err         one-cycle pulse on a bad window or REF timeout
// Modports:
//   master      environment side: drives ref_clk/en_mon, observes results
//   slave       detector side: observes ref_clk/en_mon, drives results
// ---------------------------------------------------------------------------
interface avsdpll_lock_det_if #(
    parameter int CW = 16
);
    logic          ref_clk;
    logic          en_mon;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          lock;
    logic          err;

    modport master (
        output ref_clk,
        output en_mon,
        input  count,
        input  count_valid,
        input  lock,
        input  err
    );

    modport slave (
        input  ref_clk,
        input  en_mon,
        output count,
        output count_valid,
        output lock,
        output err
    );
endinterface

// File: rtl/avsdpll_lock_det.sv
// ---------------------------------------------------------------------------
// avsdpll_lock_det
// Lock detector / frequency monitor for the avsdpll output clock. Counts CLK
// cycles per REF period (REF is synchronized into the CLK domain), checks
// each window against MULT +/- TOL and asserts lock after LOCK_CNT
// consecutive good windows. A REF period reaching 4*MULT CLK cycles is a
// timeout and drops the detector back to acquisition.
//
// Parameters:
//   MULT      expected CLK cycles per REF period
//   TOL       allowed deviation |count - MULT|
//   LOCK_CNT  consecutive good windows needed for lock (>= 1)
//   CW        period counter / count width
// Ports:
//   clk       PLL output clock, the only clock
//   rst       asynchronous active-high reset
//   bus       avsdpll_lock_det_if.slave (ref_clk, en_mon in;
//             count, count_valid, lock, err out)
//
// Build option:
//   AVSDPLL_LOCK_HYST_EN  when defined, a single bad window in LOCKED only
//                         raises err; a second consecutive bad window drops
//                         lock. A good window in between clears the miss.
// ---------------------------------------------------------------------------
module avsdpll_lock_det #(
    parameter int MULT     = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    avsdpll_lock_det_if.slave bus
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0]        CNT_MAX = '1;
    localparam logic [CW-1:0]        TIMEOUT = CW'(4 * MULT);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic signed [CW:0]   MULT_S  = (CW+1)'(MULT);
    localparam logic signed [CW:0]   TOL_S   = (CW+1)'(TOL);
    localparam logic [GW-1:0]        GCNT_LAST = GW'(LOCK_CNT - 1);
    localparam logic [GW-1:0]        GCNT_FULL = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // REF synchronizer: two metastability flops plus an edge register.
    // ------------------------------------------------------------------
    logic [2:0] sync_reg;
    logic       rd;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= bus.ref_clk;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign rd = sync_reg[1] & ~sync_reg[2];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [GW-1:0]   gcnt_reg, gcnt_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            count_valid_reg, count_valid_next;
    logic            lock_reg, lock_next;
    logic            err_reg, err_next;
`ifdef AVSDPLL_LOCK_HYST_EN
    logic            miss_reg, miss_next;
`endif

    // Window classification. cnt saturates, so the CW+1-bit signed
    // difference never wraps.
    logic signed [CW:0] diff;
    logic signed [CW:0] diff_abs;
    logic               win_good;
    logic [CW-1:0]      cnt_inc;
    logic               timeout;

    assign diff     = $signed({1'b0, cnt_reg}) - MULT_S;
    assign diff_abs = diff[CW] ? -diff : diff;
    assign win_good = (diff_abs <= TOL_S);
    assign cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign timeout  = (cnt_reg == TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            gcnt_reg        <= '0;
            count_reg       <= '0;
            count_valid_reg <= 1'b0;
            lock_reg        <= 1'b0;
            err_reg         <= 1'b0;
`ifdef AVSDPLL_LOCK_HYST_EN
            miss_reg        <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            gcnt_reg        <= gcnt_next;
            count_reg       <= count_next;
            count_valid_reg <= count_valid_next;
            lock_reg        <= lock_next;
            err_reg         <= err_next;
`ifdef AVSDPLL_LOCK_HYST_EN
            miss_reg        <= miss_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        gcnt_next        = gcnt_reg;
        count_next       = count_reg;
        count_valid_next = 1'b0;
        lock_next        = lock_reg;
        err_next         = 1'b0;
`ifdef AVSDPLL_LOCK_HYST_EN
        miss_next        = miss_reg;
`endif

        if (!bus.en_mon) begin
            // Disable overrides every state: clear everything synchronously.
            state_next = IDLE;
            cnt_next   = '0;
            gcnt_next  = '0;
            count_next = '0;
            lock_next  = 1'b0;
`ifdef AVSDPLL_LOCK_HYST_EN
            miss_next  = 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next   = '0;
                    state_next = ACQ;
                end

                ACQ: begin
                    // The window before the first edge is partial: only
                    // start counting, never report it.
                    cnt_next = rd ? CNT_ONE : cnt_inc;
                    if (rd) begin
                        state_next = TRACK;
                    end
                end

                TRACK, LOCKED: begin
                    cnt_next = rd ? CNT_ONE : cnt_inc;
                    if (rd) begin
                        // rd has priority over a coincident timeout.
                        count_next       = cnt_reg;
                        count_valid_next = 1'b1;
                        if (win_good) begin
`ifdef AVSDPLL_LOCK_HYST_EN
                            miss_next = 1'b0;
`endif
                            if (state_reg == TRACK) begin
                                if (gcnt_reg == GCNT_LAST) begin
                                    gcnt_next  = GCNT_FULL;
                                    lock_next  = 1'b1;
                                    state_next = LOCKED;
                                end else begin
                                    gcnt_next = gcnt_reg + 1'b1;
                                end
                            end
                        end else begin
                            err_next = 1'b1;
                            if (state_reg == LOCKED) begin
`ifdef AVSDPLL_LOCK_HYST_EN
                                if (miss_reg) begin
                                    state_next = TRACK;
                                    lock_next  = 1'b0;
                                    gcnt_next  = '0;
                                    miss_next  = 1'b0;
                                end else begin
                                    miss_next = 1'b1;
                                end
`else
                                state_next = TRACK;
                                lock_next  = 1'b0;
                                gcnt_next  = '0;
`endif
                            end else begin
                                gcnt_next = '0;
                            end
                        end
                    end else if (timeout) begin
                        // REF stopped (or CLK far too fast). Leaving for ACQ
                        // makes this fire once per timeout.
                        state_next = ACQ;
                        lock_next  = 1'b0;
                        gcnt_next  = '0;
                        err_next   = 1'b1;
`ifdef AVSDPLL_LOCK_HYST_EN
                        miss_next  = 1'b0;
`endif
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.count       = count_reg;
    assign bus.count_valid = count_valid_reg;
    assign bus.lock        = lock_reg;
    assign bus.err         = err_reg;

endmodule

// File: tb/tb_avsdpll_lock_det.sv
// ---------------------------------------------------------------------------
// tb_avsdpll_lock_det
// Directed bench for avsdpll_lock_det (MULT=8, TOL=1, LOCK_CNT=4, CW=16).
// A background process generates REF with a programmable period in CLK
// cycles (0 = held low, optional 7/9 alternation). REF edges are driven on
// the CLK falling edge and all outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_avsdpll_lock_det;

    logic clk;
    logic rst;

    avsdpll_lock_det_if #(.CW(16)) bus ();

    avsdpll_lock_det #(
        .MULT     (8),
        .TOL      (1),
        .LOCK_CNT (4),
        .CW       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int ref_period = 0;
    bit ref_alt = 1'b0;
    bit alt_phase = 1'b0;

    int q_count[$];
    int q_lock[$];
    int q_err[$];
    int err_extra = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // REF generator: each period starts with a rising edge on a CLK
    // falling edge; the period length is latched at the start of a period.
    initial begin
        int p;
        bus.ref_clk = 1'b0;
        @(negedge clk);
        forever begin
            p = ref_period;
            if (p != 0 && ref_alt) begin
                p = alt_phase ? p + 1 : p - 1;
                alt_phase = ~alt_phase;
            end
            if (p == 0) begin
                bus.ref_clk = 1'b0;
                @(negedge clk);
            end else begin
                bus.ref_clk = 1'b1;
                repeat (p / 2) @(negedge clk);
                bus.ref_clk = 1'b0;
                repeat (p - p / 2) @(negedge clk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Collect the next n COUNT_VALID pulses; returns on the falling edge
    // where the n-th one is seen. err pulses outside a window are counted.
    task automatic wait_cv(input int n, input string tag);
        int cyc;
        cyc = 0;
        q_count.delete();
        q_lock.delete();
        q_err.delete();
        while (q_count.size() < n && cyc < n * 12 + 40) begin
            @(negedge clk);
            cyc++;
            if (bus.count_valid) begin
                q_count.push_back(int'(bus.count));
                q_lock.push_back(int'(bus.lock));
                q_err.push_back(int'(bus.err));
                $display("[TB] %s window %0d: count=%0d lock=%0d err=%0d",
                         tag, q_count.size() - 1, bus.count, bus.lock, bus.err);
            end else if (bus.err) begin
                err_extra++;
            end
        end
        if (q_count.size() < n) begin
            check({tag, "_cv_timeout"}, q_count.size(), n);
        end
    endtask

    task automatic check_win(input string tag, input int i, input int c, input int l, input int e);
        if (i < q_count.size()) begin
            check($sformatf("%s[%0d].count", tag, i), q_count[i], c);
            check($sformatf("%s[%0d].lock", tag, i), q_lock[i], l);
            check($sformatf("%s[%0d].err", tag, i), q_err[i], e);
        end
    endtask

    initial begin
        int errs;
        int cvs;
        int lock_at_err;

        rst = 1'b1;
        bus.en_mon = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.count", bus.count, 0);
        check("rst.count_valid", bus.count_valid, 0);
        check("rst.lock", bus.lock, 0);
        check("rst.err", bus.err, 0);
        rst = 1'b0;

        // Nominal 8-cycle REF: lock on the 4th reported window
        ref_period = 8;
        repeat (20) @(negedge clk);
        bus.en_mon = 1'b1;
        wait_cv(5, "nom");
        check_win("nom", 0, 8, 0, 0);
        check_win("nom", 1, 8, 0, 0);
        check_win("nom", 2, 8, 0, 0);
        check_win("nom", 3, 8, 1, 0);
        check_win("nom", 4, 8, 1, 0);

        // Step to 10: the in-flight 8 window reports first, then the 10
        // window is bad
        ref_period = 10;
        wait_cv(2, "step");
        check_win("step", 0, 8, 1, 0);
`ifdef AVSDPLL_LOCK_HYST_EN
        check_win("step", 1, 10, 1, 1);
`else
        check_win("step", 1, 10, 0, 1);
`endif
        // Back to 8: one more 10 window in flight, then four good 8 windows
        ref_period = 8;
        wait_cv(5, "relock");
`ifdef AVSDPLL_LOCK_HYST_EN
        // Second consecutive bad window drops lock
        check_win("relock", 0, 10, 0, 1);
`else
        check_win("relock", 0, 10, 0, 1);
`endif
        check_win("relock", 1, 8, 0, 0);
        check_win("relock", 2, 8, 0, 0);
        check_win("relock", 3, 8, 0, 0);
        check_win("relock", 4, 8, 1, 0);

        // EN_MON drop while locked: clears on the next CLK edge, not before
        bus.en_mon = 1'b0;
        #1;
        check("enoff.lock_before_edge", bus.lock, 1);
        @(negedge clk);
        check("enoff.lock", bus.lock, 0);
        check("enoff.count", bus.count, 0);
        check("enoff.count_valid", bus.count_valid, 0);

        // Alternating 7/9 periods: all windows within tolerance
        ref_alt = 1'b1;
        repeat (30) @(negedge clk);
        err_extra = 0;
        bus.en_mon = 1'b1;
        wait_cv(5, "alt");
        for (int i = 0; i < q_count.size(); i++) begin
            check($sformatf("alt[%0d].count_7or9", i), (q_count[i] == 7 || q_count[i] == 9), 1);
            check($sformatf("alt[%0d].lock", i), q_lock[i], (i >= 3) ? 1 : 0);
            check($sformatf("alt[%0d].err", i), q_err[i], 0);
        end
        check("alt.err_outside_window", err_extra, 0);

        // Return to 8 while locked (last alternating window still in flight)
        ref_alt = 1'b0;
        wait_cv(3, "back8");
        check_win("back8", 1, 8, 1, 0);
        check_win("back8", 2, 8, 1, 0);

        // REF stops: single timeout err, lock drops, COUNT keeps 8
        ref_period = 0;
        errs = 0;
        cvs = 0;
        lock_at_err = -1;
        repeat (80) begin
            @(negedge clk);
            if (bus.err) begin
                errs++;
                lock_at_err = int'(bus.lock);
                $display("[TB] timeout err: lock=%0d count=%0d", bus.lock, bus.count);
            end
            if (bus.count_valid) cvs++;
        end
        check("timeout.err_pulses", errs, 1);
        check("timeout.lock_at_err", lock_at_err, 0);
        check("timeout.count_valid_pulses", cvs, 0);
        check("timeout.count", bus.count, 8);
        check("timeout.lock_after", bus.lock, 0);

        // Relock from ACQ, then asynchronous reset while locked
        ref_period = 8;
        wait_cv(5, "prerst");
        check_win("prerst", 3, 8, 1, 0);
        check_win("prerst", 4, 8, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async.lock", bus.lock, 0);
        check("rst_async.count", bus.count, 0);
        check("rst_async.count_valid", bus.count_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cv(4, "postrst");
        check_win("postrst", 0, 8, 0, 0);
        check_win("postrst", 1, 8, 0, 0);
        check_win("postrst", 2, 8, 0, 0);
        check_win("postrst", 3, 8, 1, 0);

`ifdef AVSDPLL_LOCK_HYST_EN
        // One bad window while locked keeps lock; a good one clears the miss
        ref_period = 10;
        wait_cv(1, "hyst1a");
        check_win("hyst1a", 0, 8, 1, 0);
        ref_period = 8;
        wait_cv(2, "hyst1b");
        check_win("hyst1b", 0, 10, 1, 1);
        check_win("hyst1b", 1, 8, 1, 0);

        // Two consecutive bad windows drop lock on the second
        ref_period = 10;
        wait_cv(1, "hyst2a");
        check_win("hyst2a", 0, 8, 1, 0);
        wait_cv(1, "hyst2b");
        check_win("hyst2b", 0, 10, 1, 1);
        ref_period = 8;
        wait_cv(1, "hyst2c");
        check_win("hyst2c", 0, 10, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/avsdpll_lock_det.md
# avsdpll_lock_det

Digital lock detector and frequency monitor for the avsdpll output. It runs entirely in the PLL output domain (CLK) and samples the reference (REF) through a synchronizer. It counts CLK cycles per REF period, compares each count against the expected multiplication ratio, and asserts LOCK after a run of consecutive in-tolerance periods. It is the observing end of the PLL interface: the PLL consumes REF and produces CLK, and this block consumes both to judge whether CLK is tracking REF.

## Interface
- MULT, 8: expected CLK cycles per REF period.
- TOL, 1: allowed deviation; a window is good if |COUNT − MULT| ≤ TOL.
- LOCK_CNT, 4: consecutive good windows required to assert LOCK (≥1).
- CW, 16: period counter and COUNT width.
- CLK  input  1  PLL output clock; the only clock.
- RST  input  1  asynchronous, active-high reset.
- REF  input  1  reference clock, asynchronous to CLK.
- EN_MON  input  1  monitor enable; low holds the block in IDLE.
- COUNT  output  CW  CLK cycles in the last complete REF period.
- COUNT_VALID  output  1  one-cycle pulse when COUNT updates.
- LOCK  output  1  lock indication.
- ERR  output  1  one-cycle pulse on a bad window or REF timeout while in TRACK or LOCKED.

## Operation
- REF passes through a 2-flop synchronizer and a third edge register. Rise detect is rd = s2 & ~s3.
- Period counter cnt:
  - Set to 1 on rd.
  - Otherwise increments, saturating at 2^CW−1.
  - Held at 0 in IDLE.
- States: IDLE, ACQ, TRACK, LOCKED. Good-window counter gcnt ranges 0..LOCK_CNT.
- IDLE:
  - Entered from any state when EN_MON=0; synchronous clear of cnt, gcnt, LOCK and the outputs.
  - Moves to ACQ when EN_MON=1.
- ACQ:
  - The first rd starts cnt and moves to TRACK.
  - No COUNT update: the partial window is discarded.
- TRACK / LOCKED, on each rd:
  - COUNT <= cnt and COUNT_VALID=1.
  - The window is then classified as good or bad.
- TRACK:
  - Good window: gcnt+1. When gcnt reaches LOCK_CNT, go to LOCKED with LOCK=1.
  - Bad window: gcnt=0, ERR=1, stay in TRACK.
- LOCKED:
  - Good window: stay.
  - Bad window: go to TRACK, LOCK=0, gcnt=0, ERR=1.
- Timeout: cnt reaches 4×MULT with no rd (REF stopped or CLK far fast).
  - Go to ACQ, LOCK=0, gcnt=0, ERR=1, once per timeout.
  - COUNT is not updated.
- rd and the timeout in the same cycle: rd wins, and the window is classified normally.
- Subtraction for the tolerance check uses CW+1-bit signed arithmetic. No wrap occurs because cnt saturates.

## Timing
- Reset values: COUNT=0, COUNT_VALID=0, LOCK=0, ERR=0, state IDLE, sync flops 0.
- REF rising edge to rd: 2–3 CLK cycles.
- COUNT, COUNT_VALID, LOCK and ERR are registered. They update on the CLK edge ending the rd cycle.
- LOCK changes on the same edge as the COUNT_VALID of the deciding window.
- RST mid-operation: all outputs drop immediately (asynchronous). The block restarts from IDLE after RST deasserts, and the next lock needs a discarded window plus LOCK_CNT good windows.
- EN_MON falling: outputs clear on the next CLK edge.

## Configuration
- AVSDPLL_LOCK_HYST_EN defined: in LOCKED, one bad window raises ERR but keeps LOCK. A second consecutive bad window drops to TRACK. A good window between them clears the pending miss. Timeout still drops lock immediately.
- Not defined: a single bad window drops LOCK, as described in Operation.

## Test plan
- MULT=8, REF period = 8 CLK, EN_MON=1: COUNT=8 on every COUNT_VALID. LOCK rises with the 4th COUNT_VALID, i.e. the 5th REF rise after enable.
- While locked, REF period steps to 10 CLK: COUNT=10, ERR pulses, LOCK falls on that edge. Returning to 8 gives LOCK again after 4 windows.
- Alternating REF periods of 7 and 9 CLK: all windows good, LOCK asserted after 4 windows, ERR never pulses.
- REF held low after lock: ERR pulses and LOCK falls when cnt reaches 32. COUNT keeps its last value (8).
- RST pulsed while LOCK=1: LOCK, COUNT and COUNT_VALID are 0 immediately. Relock needs 5 REF rises. Repeat with EN_MON dropped instead: clear occurs on the next CLK edge.
- With AVSDPLL_LOCK_HYST_EN defined, while locked:
  - One 10-CLK window then 8-CLK windows: ERR pulses, LOCK stays 1.
  - Two consecutive 10-CLK windows: LOCK falls on the second.
